// File: rtl/seg7_bin_display_pkg.sv
// Shared constants for the binary to seven-segment display path.
// Segment patterns are {g,f,e,d,c,b,a} and active-low; decoders invert them when needed.
package seg7_bin_display_pkg;

   localparam int NDIG  = 6;
   localparam int NSTEP = 24;
   localparam int BW    = 24;
   localparam int CW    = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Digit codes above 9 never come out of the BCD engine, so 10 marks a dash.
   localparam logic [3:0] DIG_DASH = 4'hA;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      p = SEG_DASH;
      case (d)
         4'd0: p = SEG_0;
         4'd1: p = SEG_1;
         4'd2: p = SEG_2;
         4'd3: p = SEG_3;
         4'd4: p = SEG_4;
         4'd5: p = SEG_5;
         4'd6: p = SEG_6;
         4'd7: p = SEG_7;
         4'd8: p = SEG_8;
         4'd9: p = SEG_9;
         default: p = SEG_DASH;
      endcase
      return p;
   endfunction

   function automatic logic [BW-1:0] bcd_adjust(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int i = 0; i < NDIG; i++) begin
         if (b[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One seven-segment digit: BCD code plus blank flag to segment pins.
// Polarity is selected at elaboration time.
module seg7_digit_decode
   import seg7_bin_display_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   logic [6:0] raw;

   always_comb begin
      raw = blank ? SEG_BLANK : seg_pattern(digit);
      seg = ACTIVE_LOW ? raw : ~raw;
   end

endmodule

// File: rtl/seg7_bin_display.sv
// Binary 0..999999 to six DE2 seven-segment digits via a sequential
// double-dabble engine; the display only updates when a pass completes.
module seg7_bin_display
   import seg7_bin_display_pkg::*;
#(
   parameter int MAX_VAL        = 999999,
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [BW-1:0] data,
   output logic [6:0]    hex0,
   output logic [6:0]    hex1,
   output logic [6:0]    hex2,
   output logic [6:0]    hex3,
   output logic [6:0]    hex4,
   output logic [6:0]    hex5,
   output logic          busy,
   output logic          valid
);

   localparam logic [BW-1:0] MAX_Q = BW'(MAX_VAL);
   localparam logic [CW-1:0] LAST  = CW'(NSTEP - 1);

   state_t          state;
   logic [BW-1:0]   bin_q;
   logic [BW-1:0]   last_q;
   logic [BW-1:0]   bcd;
   logic [CW-1:0]   cnt;
   logic            init;
   logic            ovr;
   logic [BW-1:0]   disp_q;
   logic [NDIG-1:0] disp_blank;

   logic [BW-1:0]   adj;
   logic [BW-1:0]   dig_nxt;
   logic [NDIG-1:0] blank_nxt;
   logic            lz;

   assign adj = bcd_adjust(bcd);

   // Leading zeros blank from the top down; the units digit is never blanked.
   always_comb begin
      dig_nxt   = bcd;
      blank_nxt = '0;
      lz        = BLANK_LZ;
      if (ovr) begin
         dig_nxt = {NDIG{DIG_DASH}};
      end else begin
         for (int i = NDIG - 1; i >= 1; i--) begin
            lz           = lz && (bcd[4*i +: 4] == 4'd0);
            blank_nxt[i] = lz;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bin_q      <= '0;
         last_q     <= '0;
         bcd        <= '0;
         cnt        <= '0;
         init       <= 1'b1;
         ovr        <= 1'b0;
         disp_q     <= '0;
         disp_blank <= '1;
         busy       <= 1'b0;
         valid      <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (init || (data != last_q)) begin
                  bin_q  <= data;
                  last_q <= data;
                  init   <= 1'b0;
                  bcd    <= '0;
                  cnt    <= '0;
                  ovr    <= (data > MAX_Q);
                  busy   <= 1'b1;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               {bcd, bin_q} <= {adj[BW-2:0], bin_q, 1'b0};
               cnt          <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= S_DONE;
            end
            S_DONE: begin
               disp_q     <= dig_nxt;
               disp_blank <= blank_nxt;
               valid      <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic [6:0] seg [NDIG];

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      seg7_digit_decode #(
         .ACTIVE_LOW(SEG_ACTIVE_LOW)
      ) u_dec (
         .digit(disp_q[4*g +: 4]),
         .blank(disp_blank[g]),
         .seg  (seg[g])
      );
   end

   assign hex0 = seg[0];
   assign hex1 = seg[1];
   assign hex2 = seg[2];
   assign hex3 = seg[3];
   assign hex4 = seg[4];
   assign hex5 = seg[5];

endmodule

// File: tb/tb_seg7_bin_display.sv
// Scoreboard bench for seg7_bin_display: three parameter variants share one
// data bus; expected digits come from decimal arithmetic on the value.
module tb_seg7_bin_display;

   localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      int unsigned val;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [23:0] data;

   logic [6:0] h0 [6];
   logic [6:0] h1 [6];
   logic [6:0] h2 [6];
   logic       busy0, busy1, busy2;
   logic       valid0, valid1, valid2;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   vcount = 0;
   exp_t q [$];
   int unsigned shown_val = 0;
   bit   have_shown = 0;

   seg7_bin_display u_dut0 (
      .clk(clk), .rst_n(rst_n), .data(data),
      .hex0(h0[0]), .hex1(h0[1]), .hex2(h0[2]),
      .hex3(h0[3]), .hex4(h0[4]), .hex5(h0[5]),
      .busy(busy0), .valid(valid0)
   );

   seg7_bin_display #(.BLANK_LZ(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data(data),
      .hex0(h1[0]), .hex1(h1[1]), .hex2(h1[2]),
      .hex3(h1[3]), .hex4(h1[4]), .hex5(h1[5]),
      .busy(busy1), .valid(valid1)
   );

   seg7_bin_display #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data(data),
      .hex0(h2[0]), .hex1(h2[1]), .hex2(h2[2]),
      .hex3(h2[3]), .hex4(h2[4]), .hex5(h2[5]),
      .busy(busy2), .valid(valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [41:0] vec(input logic [6:0] h [6]);
      return {h[5], h[4], h[3], h[2], h[1], h[0]};
   endfunction

   function automatic logic [41:0] model(input int unsigned v, input bit blz,
                                        input bit al);
      logic [41:0] r;
      logic [6:0]  p;
      int unsigned pw;
      r  = '0;
      pw = 1;
      for (int i = 0; i < 6; i++) begin
         if (v > 999999)
            p = 7'h3F;
         else if (blz && i > 0 && v < pw)
            p = 7'h7F;
         else
            p = PAT[(v / pw) % 10];
         r[7*i +: 7] = al ? p : ~p;
         pw = pw * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (valid0 || valid1 || valid2)) begin
         vcount++;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=1 required=0 t=%0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", 64'(cyc), 64'(e.due));
            chk("valid_sync", {valid0, valid1, valid2}, 3'b111);
            chk("hex_lz", 64'(vec(h0)), 64'(model(e.val, 1'b1, 1'b1)));
            chk("hex_nolz", 64'(vec(h1)), 64'(model(e.val, 1'b0, 1'b1)));
            chk("hex_inv", 64'(vec(h2)), 64'(model(e.val, 1'b0, 1'b0)));
            chk("busy_done", busy0, 1'b0);
            shown_val  = e.val;
            have_shown = 1'b1;
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=%0d required=0 pending", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic apply(input int unsigned v);
      exp_t e;
      @(posedge clk);
      #1;
      data  = 24'(v);
      e.val = v;
      e.due = cyc + 26;
      q.push_back(e);
      repeat (10) @(posedge clk);
      #1;
      chk("busy_mid", busy0, 1'b1);
      if (have_shown)
         chk("hold_mid", 64'(vec(h0)), 64'(model(shown_val, 1'b1, 1'b1)));
      wait_drain();
   endtask

   initial begin
      exp_t e;
      int   c0;
      int   vc0;
      int unsigned v;
      rst_n = 1'b0;
      data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_hex", 64'(vec(h0)), 64'(42'h3FFFFFFFFFF));
      chk("rst_hex_inv", 64'(vec(h2)), 64'(0));
      chk("rst_busy_valid", {busy0, valid0}, 2'b00);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e.val = 0;
      e.due = cyc + 26;
      q.push_back(e);
      wait_drain();

      vc0 = vcount;
      repeat (30) @(posedge clk);
      #1;
      chk("steady_busy", busy0, 1'b0);
      chk("steady_no_valid", 64'(vcount), 64'(vc0));

      apply(123456);
      apply(999999);
      apply(1000000);

      @(posedge clk);
      #1;
      c0    = cyc;
      vc0   = vcount;
      data  = 24'd42;
      e.val = 42;
      e.due = c0 + 26;
      q.push_back(e);
      repeat (10) @(posedge clk);
      #1;
      data  = 24'd999999;
      e.val = 999999;
      e.due = c0 + 52;
      q.push_back(e);
      wait_drain();
      repeat (30) @(posedge clk);
      chk("two_pulses", 64'(vcount - vc0), 64'(2));

      apply(5);

      @(posedge clk);
      #1;
      data = 24'd7;
      repeat (5) @(posedge clk);
      #1;
      rst_n      = 1'b0;
      have_shown = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_hex", 64'(vec(h0)), 64'(42'h3FFFFFFFFFF));
      chk("rst_mid_busy", {busy0, valid0}, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      e.val = 7;
      e.due = cyc + 26;
      q.push_back(e);
      wait_drain();

      for (int i = 0; i < 12; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 999);
            1: v = $urandom_range(0, 999999);
            2: v = $urandom_range(1000000, 24'hFFFFFF);
            default: v = ($urandom_range(0, 1) != 0) ? 999999 : 1000000;
         endcase
         if (v != 32'(data))
            apply(v);
      end

      apply(0);
      apply(10);
      apply(100000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
